muldiv_seq: RTL

//  Multi-cycle integer multiply/divide unit: MUL, IMUL, DIV, IDIV in byte or word mode.

---
 rtl/zet_muldiv_pkg.sv | 33 +++
 rtl/muldiv_seq_div_step.sv | 33 +++
 rtl/muldiv_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zet_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : zet_muldiv_pkg                                                |
// | Description: Shared encodings for the sequential multiply/divide unit:     |
// |              function codes, FSM states and counter sizing helper.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package zet_muldiv_pkg;

  // Operation select as presented on the func port
  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_IMUL = 2'b01,
    MD_DIV  = 2'b10,
    MD_IDIV = 2'b11
  } md_func_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } md_state_e;

  // Step counter must hold values up to the full word width
  function automatic int md_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : div_step                                                      |
// | Description: One restoring-division step. Shifts the next dividend bit     |
// |              (MSB of quo) into the partial remainder, subtracts the        |
// |              divisor when it fits and shifts the quotient bit into quo.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module div_step #(
  parameter int WD = 17
) (
  input  logic [WD-1:0] rem_i,
  input  logic [WD-1:0] quo_i,
  input  logic [WD-1:0] dvs_i,
  output logic [WD-1:0] rem_o,
  output logic [WD-1:0] quo_o
);

  logic [WD:0]   w_shift;
  logic [WD-1:0] w_diff;
  logic          w_ge;

  // Trial subtraction; shifted value kept one bit wider so the compare is exact
  always_comb begin
    w_shift = {rem_i, quo_i[WD-1]};
    w_ge    = (w_shift >= {1'b0, dvs_i});
    w_diff  = w_shift[WD-1:0] - dvs_i;
    rem_o   = w_ge ? w_diff : w_shift[WD-1:0];
    quo_o   = {quo_i[WD-2:0], w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : muldiv_seq                                                    |
// | Description: Multi-cycle MUL/IMUL/DIV/IDIV unit, byte (W/2) or word (W)    |
// |              mode, start/done handshake, divide-error detection.           |
// |              MULDIV_SEQ_FAST_MUL_EN: single-cycle multiplier for MUL/IMUL  |
// |              (3-cycle latency); undefined: shift-add over N cycles.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module muldiv_seq
  import zet_muldiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     func,
  input  logic           word_op,
  input  logic [2*W-1:0] x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] o,
  output logic           cfo,
  output logic           ofo,
  output logic           div_err
);

  localparam int HW = W / 2;
  localparam int CW = md_cnt_width(W);

  md_state_e      state_q, state_d;
  logic [1:0]     func_q, func_d;
  logic           word_q, word_d;
  logic [2*W-1:0] x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   dvs_q, dvs_d;      // divisor magnitude or multiplicand magnitude
  logic [W:0]     rem_q, rem_d;      // partial remainder
  logic [W:0]     quo_q, quo_d;      // dividend-low / quotient, or multiplier bits
  logic [2*W-1:0] prod_q, prod_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           ovf_q, ovf_d;      // IDIV high-half magnitude >= divisor
  logic [2*W-1:0] o_q, o_d;
  logic           cf_q, cf_d;
  logic           err_q, err_d;

  // Operand conditioning and result formatting
  logic           w_signed, w_is_div;
  logic [W-1:0]   w_y_ext, w_y_mag, w_a_ext, w_a_mag, w_mplr;
  logic           w_y_neg, w_a_neg, w_dd_neg, w_hi_ovf;
  logic [2*W-1:0] w_dd_ext, w_dd_mag;
  logic [W-1:0]   w_dd_hi, w_dd_lo;
  logic [2*W-1:0] w_prod_s, w_mul_o, w_lo_ext, w_div_o;
  logic           w_mul_cf, w_q_range, w_div_ovf;
  logic [W-1:0]   w_quo_s, w_rem_s, w_half;
  logic [CW-1:0]  w_last;
  logic [W:0]     w_step_rem, w_step_quo;

  div_step #(
    .WD (W + 1)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i ({1'b0, dvs_q}),
    .rem_o (w_step_rem),
    .quo_o (w_step_quo)
  );

`ifdef MULDIV_SEQ_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  assign w_fast_prod = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_y_mag};
`endif

  // Sign-extend to full width, take magnitudes, align byte-mode operands, format results
  always_comb begin
    w_signed  = func_q[0];
    w_is_div  = func_q[1];
    w_y_ext   = word_q ? y_q : {{HW{w_signed & y_q[HW-1]}}, y_q[HW-1:0]};
    w_y_neg   = w_signed & w_y_ext[W-1];
    w_y_mag   = w_y_neg ? -w_y_ext : w_y_ext;
    w_a_ext   = word_q ? x_q[W-1:0] : {{HW{w_signed & x_q[HW-1]}}, x_q[HW-1:0]};
    w_a_neg   = w_signed & w_a_ext[W-1];
    w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
    w_dd_ext  = word_q ? x_q : {{W{w_signed & x_q[W-1]}}, x_q[W-1:0]};
    w_dd_neg  = w_signed & w_dd_ext[2*W-1];
    w_dd_mag  = w_dd_neg ? -w_dd_ext : w_dd_ext;
    // Byte mode left-aligns the low half so the step logic always reads the MSB
    w_dd_hi   = word_q ? w_dd_mag[2*W-1:W] : {{HW{1'b0}}, w_dd_mag[W-1:HW]};
    w_dd_lo   = word_q ? w_dd_mag[W-1:0] : {w_dd_mag[HW-1:0], {HW{1'b0}}};
    w_mplr    = word_q ? w_y_mag : {w_y_mag[HW-1:0], {HW{1'b0}}};
    w_hi_ovf  = (w_dd_hi >= w_y_mag);
    w_last    = word_q ? CW'(W - 1) : CW'(HW - 1);

    w_prod_s  = neg_res_q ? -prod_q : prod_q;
    w_mul_o   = word_q ? w_prod_s : {{W{1'b0}}, w_prod_s[W-1:0]};
    if (word_q) begin
      w_lo_ext = {{W{w_signed & w_prod_s[W-1]}}, w_prod_s[W-1:0]};
    end else begin
      w_lo_ext = {{W{1'b0}}, {HW{w_signed & w_prod_s[HW-1]}}, w_prod_s[HW-1:0]};
    end
    w_mul_cf  = (w_mul_o != w_lo_ext);

    w_quo_s   = neg_res_q ? -quo_q[W-1:0] : quo_q[W-1:0];
    w_rem_s   = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    w_div_o   = word_q ? {w_rem_s, w_quo_s}
                       : {{W{1'b0}}, w_rem_s[HW-1:0], w_quo_s[HW-1:0]};
    // Largest legal magnitude is 2^(N-1) for a negative quotient, 2^(N-1)-1 otherwise
    w_half    = word_q ? {1'b1, {(W-1){1'b0}}} : {{HW{1'b0}}, 1'b1, {(HW-1){1'b0}}};
    w_q_range = neg_res_q ? (quo_q[W-1:0] > w_half) : (quo_q[W-1:0] >= w_half);
    w_div_ovf = (func_q == MD_IDIV) & (ovf_q | w_q_range);
  end

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    word_d    = word_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    ovf_d     = ovf_q;
    o_d       = o_q;
    cf_d      = cf_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d  = func;
          word_d  = word_op;
          x_d     = x;
          y_d     = y;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d     = '0;
        neg_rem_d = w_dd_neg;
        ovf_d     = w_hi_ovf;
        if (w_is_div) begin
          neg_res_d = w_dd_neg ^ w_y_neg;
          dvs_d     = w_y_mag;
          rem_d     = {1'b0, w_dd_hi};
          quo_d     = {w_dd_lo, 1'b0};
          // Divide by zero, or unsigned quotient that cannot fit in N bits
          if ((w_y_mag == '0) || (!w_signed && w_hi_ovf)) begin
            err_d   = 1'b1;
            cf_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end else begin
          neg_res_d = w_a_neg ^ w_y_neg;
          dvs_d     = w_a_mag;
          quo_d     = {w_mplr, 1'b0};
`ifdef MULDIV_SEQ_FAST_MUL_EN
          prod_d    = w_fast_prod;
          state_d   = S_FIX;
`else
          prod_d    = '0;
          state_d   = S_ITER;
`endif
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (w_is_div) begin
          rem_d = w_step_rem;
          quo_d = w_step_quo;
        end else begin
          prod_d = {prod_q[2*W-2:0], 1'b0} + (quo_q[W] ? {{W{1'b0}}, dvs_q} : '0);
          quo_d  = {quo_q[W-1:0], 1'b0};
        end
        if (cnt_q == w_last) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (w_is_div) begin
          cf_d = 1'b0;
          if (w_div_ovf) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            o_d   = w_div_o;
          end
        end else begin
          err_d = 1'b0;
          cf_d  = w_mul_cf;
          o_d   = w_mul_o;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      word_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      o_q       <= '0;
      cf_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      word_q    <= word_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      ovf_q     <= ovf_d;
      o_q       <= o_d;
      cf_q      <= cf_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign o       = o_q;
  assign cfo     = cf_q;
  assign ofo     = cf_q;
  assign div_err = err_q;

endmodule
`default_nettype wire
